// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: state encoding,
// reset/increment defaults and the instruction alignment check.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INC_DEF      = 4;
  localparam logic [1:0]  ALIGN_MASK   = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_stage_if.sv
// Redirect inputs and fetch handshake of the PC stage. The master side is the
// PC stage itself; the slave side is fetch/redirect control.
interface pc_next_stage_if #(
  parameter int WIDTH = 32
);
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             stall;
  logic             pc_ready;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             pc_valid;
  logic             misaligned;
  logic [31:0]      issue_count;

  modport master (
    input  jump, jump_target, branch_taken, branch_target, stall, pc_ready,
    output pc, pc_plus4, pc_valid, misaligned, issue_count
  );

  modport slave (
    output jump, jump_target, branch_taken, branch_target, stall, pc_ready,
    input  pc, pc_plus4, pc_valid, misaligned, issue_count
  );
endinterface

// File: rtl/pc_reg.sv
// Load-enabled register with asynchronous active-low reset to RST_VAL.
module pc_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  val_q <= RST_VAL;
    else if (en) val_q <= d;
  end

  assign q = val_q;
endmodule

// File: rtl/yMux.sv
// Generic SIZE-bit 2:1 mux shared across the datapath: z = c ? b : a.
module yMux #(
  parameter int SIZE = 2
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c
);
  assign z = c ? b : a;
endmodule

// File: rtl/pc_next_stage.sv
// Program-counter stage: holds the PC, offers it to fetch with valid/ready,
// applies jump/branch redirects and traps misaligned targets until reset.
module pc_next_stage
  import pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
  parameter int               INC      = INC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_next_stage_if.master       bus
);

  pc_state_e        state_q, state_d;
  logic             pc_valid_q, pc_valid_d;
  logic             misaligned_q, misaligned_d;
  logic [31:0]      count_q, count_d;
  logic             pc_load;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] inc_or_branch;
  logic [WIDTH-1:0] pc_d;
  logic             redirect;
  logic             accept;

  assign pc_inc   = pc_q + WIDTH'(INC);
  assign redirect = bus.jump | bus.branch_taken;
  assign accept   = pc_valid_q & bus.pc_ready & ~bus.stall;

  // Jump sits on the outer mux so it overrides a simultaneous branch.
  yMux #(.SIZE(WIDTH)) u_mux_branch (
    .z(inc_or_branch), .a(pc_inc), .b(bus.branch_target), .c(bus.branch_taken)
  );
  yMux #(.SIZE(WIDTH)) u_mux_jump (
    .z(pc_d), .a(inc_or_branch), .b(bus.jump_target), .c(bus.jump)
  );

  pc_reg #(.WIDTH(WIDTH), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .rst_n(rst_n), .en(pc_load), .d(pc_d), .q(pc_q)
  );

  always_comb begin
    state_d      = state_q;
    pc_valid_d   = pc_valid_q;
    misaligned_d = misaligned_q;
    count_d      = count_q;
    pc_load      = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (accept) count_d = count_q + 32'd1;
        // A redirect flushes the presented PC, so stall/ready do not gate it.
        if (redirect) begin
          pc_load = 1'b1;
          if (is_misaligned(pc_d[1:0])) begin
            state_d      = FAULT;
            pc_valid_d   = 1'b0;
            misaligned_d = 1'b1;
          end
        end else if (accept) begin
          pc_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_valid_q   <= pc_valid_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_inc;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.issue_count = count_q;

endmodule
